// File: rtl/sc_cpu_io_test_if.sv
// Board I/O bundle of the bring-up core: switch operands in, LED and
// multiplexed seven-segment drive out.
interface sc_cpu_io_test_if;
  logic [4:0]  sw_pin;
  logic [4:0]  dip_pin;
  logic [0:7]  seg_data_0_pin;
  logic [0:7]  seg_data_1_pin;
  logic [7:0]  seg_cs_pin;
  logic [15:0] led_pin;

  modport master (
    output sw_pin, dip_pin,
    input  seg_data_0_pin, seg_data_1_pin, seg_cs_pin, led_pin
  );

  modport slave (
    input  sw_pin, dip_pin,
    output seg_data_0_pin, seg_data_1_pin, seg_cs_pin, led_pin
  );
endinterface

// File: rtl/sc_cpu_io_test.sv
// Four-instruction core: IN sw, IN dip, ADD, OUT to LEDs and 8 scanned 7-seg digits.
// Latency: latches update on the 4th edge of each loop; scan step every SCAN_DIV cycles.
// No backpressure; SC_IOTEST_SEG_INVERT_EN inverts segment and digit-select drive.
module sc_cpu_io_test #(
  parameter int unsigned SCAN_DIV = 4
) (
  input logic            sys_clk_in,
  input logic            sys_rst_n,
  sc_cpu_io_test_if.slave io
);

  typedef enum logic [1:0] {
    PC_IN_A = 2'd0,
    PC_IN_B = 2'd1,
    PC_ADD  = 2'd2,
    PC_OUT  = 2'd3
  } pc_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  pc_t         pc, pc_nxt;
  logic [4:0]  r1, r2;
  logic [5:0]  r3;
  logic [4:0]  a_lat, b_lat;
  logic [5:0]  s_lat;
  logic [15:0] div_cnt;
  logic [1:0]  scan_idx;
  logic [0:7]  seg0, seg1;
  logic [7:0]  cs;

  // Reset is active-high despite the port name.
  always_ff @(posedge sys_clk_in) begin
    if (sys_rst_n) pc <= PC_IN_A;
    else           pc <= pc_nxt;
  end

  always_comb begin
    pc_nxt = PC_IN_A;
    case (pc)
      PC_IN_A: pc_nxt = PC_IN_B;
      PC_IN_B: pc_nxt = PC_ADD;
      PC_ADD:  pc_nxt = PC_OUT;
      PC_OUT:  pc_nxt = PC_IN_A;
      default: pc_nxt = PC_IN_A;
    endcase
  end

  always_ff @(posedge sys_clk_in) begin
    if (sys_rst_n) begin
      r1    <= '0;
      r2    <= '0;
      r3    <= '0;
      a_lat <= '0;
      b_lat <= '0;
      s_lat <= '0;
    end else begin
      case (pc)
        PC_IN_A: r1 <= io.sw_pin;
        PC_IN_B: r2 <= io.dip_pin;
        PC_ADD:  r3 <= {1'b0, r1} + {1'b0, r2};
        PC_OUT: begin
          a_lat <= r1;
          b_lat <= r2;
          s_lat <= r3;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_in) begin
    if (sys_rst_n) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      div_cnt  <= div_cnt + 16'd1;
    end
  end

  // Values never exceed 62, so a compare chain replaces a divider.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t, u;
    if      (v >= 6'd60) t = 4'd6;
    else if (v >= 6'd50) t = 4'd5;
    else if (v >= 6'd40) t = 4'd4;
    else if (v >= 6'd30) t = 4'd3;
    else if (v >= 6'd20) t = 4'd2;
    else if (v >= 6'd10) t = 4'd1;
    else                 t = 4'd0;
    u = v[3:0] - t * 4'd10;
    return {t, u};
  endfunction

  function automatic logic [0:7] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 8'b11111100;
      4'd1:    return 8'b01100000;
      4'd2:    return 8'b11011010;
      4'd3:    return 8'b11110010;
      4'd4:    return 8'b01100110;
      4'd5:    return 8'b10110110;
      4'd6:    return 8'b10111110;
      4'd7:    return 8'b11100000;
      4'd8:    return 8'b11111110;
      4'd9:    return 8'b11110110;
      default: return 8'b00000000;
    endcase
  endfunction

  logic [7:0] a_bcd, b_bcd, s_bcd;
  assign a_bcd = to_bcd({1'b0, a_lat});
  assign b_bcd = to_bcd({1'b0, b_lat});
  assign s_bcd = to_bcd(s_lat);

  always_comb begin
    seg0 = 8'b00000000;
    seg1 = 8'b00000000;
    case (scan_idx)
      2'd0: begin seg0 = glyph(s_bcd[3:0]); seg1 = glyph(b_bcd[3:0]); end
      2'd1: begin seg0 = glyph(s_bcd[7:4]); seg1 = glyph(b_bcd[7:4]); end
      2'd2: seg1 = glyph(a_bcd[3:0]);
      2'd3: seg1 = glyph(a_bcd[7:4]);
      default: ;
    endcase
  end

  assign cs         = 8'h11 << scan_idx;
  assign io.led_pin = {a_lat, b_lat, s_lat};

`ifdef SC_IOTEST_SEG_INVERT_EN
  assign io.seg_data_0_pin = ~seg0;
  assign io.seg_data_1_pin = ~seg1;
  assign io.seg_cs_pin     = ~cs;
`else
  assign io.seg_data_0_pin = seg0;
  assign io.seg_data_1_pin = seg1;
  assign io.seg_cs_pin     = cs;
`endif

endmodule

// File: tb/tb_sc_cpu_io_test.sv
// Directed vector bench for sc_cpu_io_test (SCAN_DIV=4, active-high segments).
module tb_sc_cpu_io_test;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  sc_cpu_io_test_if io ();

  sc_cpu_io_test #(.SCAN_DIV(4)) dut (
    .sys_clk_in (clk),
    .sys_rst_n  (rst),
    .io         (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  sw;
    logic [4:0]  dip;
    logic [15:0] led;
    logic [3:0]  at, au, bt, bu, st, su;
  } vec_t;

  vec_t       vec[6];
  logic [7:0] font[10];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_digits(input int vi, input vec_t v);
    logic [7:0] want_cs, d0, d1, e0, e1;
    int         waited;
    for (int k = 0; k < 4; k++) begin
      want_cs = 8'h11 << k;
      waited  = 0;
      while (io.seg_cs_pin !== want_cs && waited < 20) begin
        tick();
        waited++;
      end
      check($sformatf("v%0d cs k%0d", vi, k), {8'h00, io.seg_cs_pin}, {8'h00, want_cs});
      case (k)
        0:       begin e0 = font[v.su]; e1 = font[v.bu]; end
        1:       begin e0 = font[v.st]; e1 = font[v.bt]; end
        2:       begin e0 = 8'h00;      e1 = font[v.au]; end
        default: begin e0 = 8'h00;      e1 = font[v.at]; end
      endcase
      d0 = io.seg_data_0_pin;
      d1 = io.seg_data_1_pin;
      check($sformatf("v%0d bank0 k%0d", vi, k), {8'h00, d0}, {8'h00, e0});
      check($sformatf("v%0d bank1 k%0d", vi, k), {8'h00, d1}, {8'h00, e1});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    font[0] = 8'b11111100; font[1] = 8'b01100000; font[2] = 8'b11011010;
    font[3] = 8'b11110010; font[4] = 8'b01100110; font[5] = 8'b10110110;
    font[6] = 8'b10111110; font[7] = 8'b11100000; font[8] = 8'b11111110;
    font[9] = 8'b11110110;

    vec[0] = '{5'd0,  5'd0,  16'h0000, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    vec[1] = '{5'd1,  5'd2,  16'h0883, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3};
    vec[2] = '{5'd2,  5'd3,  16'h10C5, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0, 4'd5};
    vec[3] = '{5'd3,  5'd4,  16'h1907, 4'd0, 4'd3, 4'd0, 4'd4, 4'd0, 4'd7};
    vec[4] = '{5'd31, 5'd31, 16'hFFFE, 4'd3, 4'd1, 4'd3, 4'd1, 4'd6, 4'd2};
    vec[5] = '{5'd10, 5'd5,  16'h514F, 4'd1, 4'd0, 4'd0, 4'd5, 4'd1, 4'd5};

    // Reset held three cycles.
    io.sw_pin  = 5'd0;
    io.dip_pin = 5'd0;
    rst = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    check("reset led", io.led_pin, 16'h0000);
    check("reset cs", {8'h00, io.seg_cs_pin}, 16'h0011);
    check("reset seg0", {8'h00, io.seg_data_0_pin}, 16'h00FC);
    check("reset seg1", {8'h00, io.seg_data_1_pin}, 16'h00FC);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      io.sw_pin  = vec[i].sw;
      io.dip_pin = vec[i].dip;
      repeat (10) tick();
      check($sformatf("v%0d led", i), io.led_pin, vec[i].led);
      check_digits(i, vec[i]);
    end

    // Scan sequence right after reset release.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [7:0] want;
      want = 8'h11 << ((i / 4) % 4);
      check($sformatf("scan %0d", i), {8'h00, io.seg_cs_pin}, {8'h00, want});
      tick();
    end

    // Reset arriving at PC2, then input change between PC0 and PC3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    io.sw_pin  = 5'd3;
    io.dip_pin = 5'd4;
    repeat (6) tick();
    check("pre-reset led", io.led_pin, 16'h1907);
    rst = 1'b1;
    io.sw_pin  = 5'd5;
    io.dip_pin = 5'd6;
    tick();
    check("midloop reset led", io.led_pin, 16'h0000);
    check("midloop reset cs", {8'h00, io.seg_cs_pin}, 16'h0011);
    rst = 1'b0;
    tick();
    io.sw_pin = 5'd7;
    tick();
    check("post-release edge2 led", io.led_pin, 16'h0000);
    tick();
    check("post-release edge3 led", io.led_pin, 16'h0000);
    tick();
    check("post-release edge4 led", io.led_pin, 16'h298B);
    repeat (4) tick();
    check("next loop led", io.led_pin, 16'h398D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
